// File: rtl/data_unpack_pkg.sv
// Shared constants, FSM state encoding and CRC-16 helper for the data_unpack packet receiver.
// Packet: header 8'h3C, 128 payload bytes MSB byte first, CRC[15:8], CRC[7:0].
package data_unpack_pkg;

   localparam logic [7:0]  PKT_HEADER    = 8'h3C;
   localparam int          PAYLOAD_BYTES = 128;
   localparam int          PKT_BYTES     = 131;
   localparam logic [15:0] CRC16_POLY    = 16'h8005;
   localparam logic [15:0] CRC16_INIT    = 16'h0000;
   localparam int          CNT_W         = $clog2(PAYLOAD_BYTES);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      CRC_HI = 3'd2,
      CRC_LO = 3'd3,
      DONE   = 3'd4
   } state_e;

   // One byte of CRC-16, MSB-first, no reflection.
   function automatic logic [15:0] crc16_byte(input logic [7:0] d, input logic [15:0] c);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0};
         if (fb) begin
            r = r ^ CRC16_POLY;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/data_unpack_crc16_d8.sv
// Combinational CRC-16 (poly 16'h8005) update for one 8-bit data word.
// Only instantiated when DATA_UNPACK_CRC_CHECK_EN is defined.
module crc16_d8
   import data_unpack_pkg::*;
(
   input  logic [7:0]  data_in,
   input  logic [15:0] crc_in,
   output logic [15:0] crc_out
);

   // Next CRC after absorbing data_in.
   always_comb begin
      crc_out = crc16_byte(data_in, crc_in);
   end

endmodule

// File: rtl/data_unpack.sv
// Packet unpacker: hunts for the header, recovers a 1024-bit payload and its CRC.
// Define DATA_UNPACK_CRC_CHECK_EN to compute/check the CRC; otherwise crc_err is tied to 0.
module data_unpack
   import data_unpack_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [7:0]    in_byte,
   output logic          in_ready,
   output logic [1023:0] data_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          crc_err,
   output logic [7:0]    drop_count
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1023:0]        data_q, data_d;
   logic [7:0]           drop_q, drop_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;
   logic                 accept_s;

`ifdef DATA_UNPACK_CRC_CHECK_EN
   logic [15:0]          crc_q, crc_d;
   logic [15:0]          crc_next_s;
   logic [15:0]          rx_crc_q, rx_crc_d;
   logic                 crc_err_q, crc_err_d;

   crc16_d8 u_crc16_d8 (
      .data_in (in_byte),
      .crc_in  (crc_q),
      .crc_out (crc_next_s)
   );
`endif

   assign accept_s = in_valid && in_ready_q;

   // Next-state, datapath and output-register computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      drop_d      = drop_q;
      out_valid_d = out_valid_q;
`ifdef DATA_UNPACK_CRC_CHECK_EN
      crc_d       = crc_q;
      rx_crc_d    = rx_crc_q;
      crc_err_d   = crc_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept_s && (in_byte == PKT_HEADER)) begin
               state_d = DATA;
               cnt_d   = '0;
`ifdef DATA_UNPACK_CRC_CHECK_EN
               crc_d   = CRC16_INIT;
`endif
            end else if (accept_s) begin
               drop_d = (drop_q == 8'hFF) ? 8'hFF : (drop_q + 8'd1);
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (accept_s) begin
               data_d = {data_q[1015:0], in_byte};
               cnt_d  = cnt_q + CNT_W'(1);
`ifdef DATA_UNPACK_CRC_CHECK_EN
               crc_d  = crc_next_s;
`endif
               if (cnt_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
                  state_d = CRC_HI;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         CRC_HI: begin
            if (accept_s) begin
`ifdef DATA_UNPACK_CRC_CHECK_EN
               rx_crc_d[15:8] = in_byte;
`endif
               state_d = CRC_LO;
            end else begin
               state_d = CRC_HI;
            end
         end
         CRC_LO: begin
            if (accept_s) begin
`ifdef DATA_UNPACK_CRC_CHECK_EN
               rx_crc_d[7:0] = in_byte;
               crc_err_d     = ({rx_crc_q[15:8], in_byte} != crc_q);
`endif
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               state_d = CRC_LO;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
`ifdef DATA_UNPACK_CRC_CHECK_EN
               crc_err_d   = 1'b0;
`endif
               state_d     = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
      // in_ready is registered, so it tracks the state being entered.
      in_ready_d = (state_d != DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         drop_q      <= 8'd0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         drop_q      <= drop_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

`ifdef DATA_UNPACK_CRC_CHECK_EN
   // CRC accumulator, received CRC and error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q     <= CRC16_INIT;
         rx_crc_q  <= 16'h0000;
         crc_err_q <= 1'b0;
      end else begin
         crc_q     <= crc_d;
         rx_crc_q  <= rx_crc_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign crc_err = crc_err_q;
`else
   assign crc_err = 1'b0;
`endif

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign data_out   = data_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_data_unpack.sv
// Randomized self-checking bench for data_unpack against a packet-level reference model.
module tb_data_unpack;

`ifdef DATA_UNPACK_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [7:0]    in_byte;
   logic          in_ready;
   logic [1023:0] data_out;
   logic          out_valid;
   logic          out_ready;
   logic          crc_err;
   logic [7:0]    drop_count;

   int unsigned   cyc = 0;
   int            n_checks = 0;
   int            n_pass = 0;
   int            exp_drop = 0;

   data_unpack dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_byte    (in_byte),
      .in_ready   (in_ready),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .crc_err    (crc_err),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      string so, se;
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         so = $sformatf("%0h", obs);
         se = $sformatf("%0h", exp);
         if (so.len() > 200) so = {"..", so.substr(so.len() - 200, so.len() - 1)};
         if (se.len() > 200) se = {"..", se.substr(se.len() - 200, se.len() - 1)};
         $display("FAIL %s: got %s expected %s", tag, so, se);
      end
   endtask

   // Reference CRC: long division of the payload bit stream, augmented by 16 zero bits.
   function automatic logic [15:0] ref_crc(input logic [1023:0] d);
      logic [16:0] rem;
      logic        b;
      rem = 17'h0;
      for (int i = 1039; i >= 0; i--) begin
         b   = (i >= 16) ? d[i - 16] : 1'b0;
         rem = {rem[15:0], b};
         if (rem[16]) rem = rem ^ 17'h18005;
      end
      return rem[15:0];
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_byte  = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_packet(input logic [1023:0] d, input logic [15:0] crc, input int max_gap);
      send_byte(8'h3C, $urandom_range(0, max_gap));
      for (int i = 0; i < 128; i++) begin
         send_byte(d[1023 - 8 * i -: 8], $urandom_range(0, max_gap));
      end
      send_byte(crc[15:8], $urandom_range(0, max_gap));
      check("no_early_valid", {1023'd0, out_valid}, 1024'd0);
      send_byte(crc[7:0], $urandom_range(0, max_gap));
   endtask

   task automatic expect_packet(input string tag, input logic [1023:0] d, input logic err, input int hold);
      int w;
      w = 0;
      while (!out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_valid"}, {1023'd0, out_valid}, 1024'd1);
      check({tag, "_data"}, data_out, d);
      check({tag, "_crc_err"}, {1023'd0, crc_err}, {1023'd0, err});
      check({tag, "_drop"}, {1016'd0, drop_count}, exp_drop);
      if (hold > 0) begin
         check({tag, "_in_ready_done"}, {1023'd0, in_ready}, 1024'd0);
         repeat (hold) @(negedge clk);
         check({tag, "_hold_valid"}, {1023'd0, out_valid}, 1024'd1);
         check({tag, "_hold_data"}, data_out, d);
         check({tag, "_hold_err"}, {1023'd0, crc_err}, {1023'd0, err});
         check({tag, "_hold_in_ready"}, {1023'd0, in_ready}, 1024'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_released"}, {1023'd0, out_valid}, 1024'd0);
      check({tag, "_in_ready_idle"}, {1023'd0, in_ready}, 1024'd1);
   endtask

   initial begin
      logic [1023:0] d;
      logic [15:0]   c;
      logic [7:0]    g;
      int unsigned   cyc0;
      bit            bad;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {1023'd0, out_valid}, 1024'd0);
      check("rst_data", data_out, 1024'd0);
      check("rst_crc_err", {1023'd0, crc_err}, 1024'd0);
      check("rst_drop", {1016'd0, drop_count}, 1024'd0);
      check("rst_in_ready", {1023'd0, in_ready}, 1024'd1);
      reset = 1'b0;
      @(negedge clk);

      // All-zero packet: latency, then hold with out_ready low.
      cyc0 = cyc;
      send_packet(1024'd0, ref_crc(1024'd0), 0);
      check("zero_latency", cyc - cyc0, 1024'd131);
      expect_packet("zero", 1024'd0, 1'b0, 10);

      // Repeating A5 payload, then single flipped data bit with the original CRC.
      d = {128{8'hA5}};
      send_packet(d, ref_crc(d), 0);
      expect_packet("a5", d, 1'b0, 0);
      send_packet(d ^ 1024'd1, ref_crc(d), 0);
      expect_packet("a5_flip", d ^ 1024'd1, CRC_EN, 0);

      // Corrupted CRC bytes still take the same time.
      cyc0 = cyc;
      send_packet(1024'd0, 16'h1234, 0);
      check("bad_crc_latency", cyc - cyc0, 1024'd131);
      expect_packet("bad_crc", 1024'd0, CRC_EN, 0);

      // Hunting: two non-header bytes, then a packet.
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      exp_drop += 2;
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send_packet(d, ref_crc(d), 0);
      expect_packet("after_drop", d, 1'b0, 0);

      // out_ready held high throughout with random input gaps.
      out_ready = 1'b1;
      d = {32{$urandom}};
      d[1023:1016] = 8'h3C;
      send_packet(d, ref_crc(d), 3);
      expect_packet("ready_high", d, 1'b0, 0);

      // Garbage flood saturates drop_count.
      for (int i = 0; i < 300; i++) begin
         g = 8'($urandom);
         if (g == 8'h3C) g = 8'h3D;
         send_byte(g, 0);
         if (exp_drop < 255) exp_drop++;
      end
      check("drop_sat", {1016'd0, drop_count}, 1024'd255);

      // Reset in the middle of a packet.
      send_byte(8'h3C, 0);
      for (int i = 0; i < 50; i++) send_byte(8'($urandom), 0);
      reset = 1'b1;
      @(negedge clk);
      exp_drop = 0;
      check("midrst_valid", {1023'd0, out_valid}, 1024'd0);
      check("midrst_data", data_out, 1024'd0);
      check("midrst_drop", {1016'd0, drop_count}, 1024'd0);
      reset = 1'b0;
      @(negedge clk);
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send_packet(d, ref_crc(d), 1);
      expect_packet("post_rst", d, 1'b0, 0);

      // Random packets with header values embedded in payload and occasional bad CRC.
      for (int p = 0; p < 4; p++) begin
         d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         d[8 * $urandom_range(0, 127) +: 8] = 8'h3C;
         bad = 1'($urandom_range(0, 1));
         c = ref_crc(d);
         if (bad) c = c ^ (16'h0001 << $urandom_range(0, 15));
         else if (p == 0) c = {8'h3C, c[7:0]} ^ {8'h00, 8'h00} ^ ({8'h3C, 8'h00} ^ {c[15:8], 8'h00}) ^ {c[15:8] ^ 8'h3C, 8'h00};
         send_packet(d, c, 2);
         expect_packet($sformatf("rnd%0d", p), d, CRC_EN && (c != ref_crc(d)), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
